// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the L1 line <-> 64-bit burst memory adapter.
// Line and beat geometry live here so the adapter and its users agree on widths.
package cacheline_adapter_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int ADDR_W  = 32;
  localparam int OFFS_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } adapter_state_e;

  typedef logic [LINE_W-1:0]  line_t;
  typedef logic [BURST_W-1:0] beat_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Clears the byte-within-line offset so every burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Converts one L1 line read/write into a 4-beat memory burst; line_resp pulses the cycle after the last resp_i.
// Memory stalls by withholding resp_i; optional ADAPTER_PERF_CNT_EN adds perf_reads/perf_writes counters.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        line_read,
  input  logic        line_write,
  input  logic [31:0] line_address,
  input  line_t       line_wdata,
  output line_t       line_rdata,
  output logic        line_resp,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output beat_t       burst_o,
  input  beat_t       burst_i,
  input  logic        resp_i
`ifdef ADAPTER_PERF_CNT_EN
  ,
  output logic [31:0] perf_reads,
  output logic [31:0] perf_writes
`endif
);

  adapter_state_e state_q, state_d;
  cnt_t           cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  line_t          wdata_q, wdata_d;
  line_t          rdata_q, rdata_d;
  logic           beat_ack;
  logic           last_beat;

  // resp_i only counts while a burst is in flight.
  assign beat_ack  = resp_i && ((state_q == RD) || (state_q == WR));
  assign last_beat = beat_ack && (cnt_q == cnt_t'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          state_d = WR;
        end else if (line_read) begin
          state_d = RD;
        end
      end
      RD, WR: begin
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    line_resp = 1'b0;
    burst_o   = '0;
    case (state_q)
      RD: read_o = 1'b1;
      WR: begin
        write_o = 1'b1;
        burst_o = wdata_q[int'(cnt_q)*BURST_W +: BURST_W];
      end
      DONE:    line_resp = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
      if (line_write || line_read) begin
        addr_d = line_align(line_address);
      end
      if (line_write) begin
        wdata_d = line_wdata;
      end
    end
    if (beat_ack) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      if (state_q == RD) begin
        rdata_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
      end
    end
    if (state_q == DONE) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign address_o  = addr_q;
  assign line_rdata = rdata_q;

`ifdef ADAPTER_PERF_CNT_EN
  logic [31:0] perf_rd_q, perf_rd_d;
  logic [31:0] perf_wr_q, perf_wr_d;

  always_comb begin
    perf_rd_d = perf_rd_q;
    perf_wr_d = perf_wr_q;
    if (last_beat && (state_q == RD)) begin
      perf_rd_d = perf_rd_q + 32'd1;
    end
    if (last_beat && (state_q == WR)) begin
      perf_wr_d = perf_wr_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      perf_rd_q <= perf_rd_d;
      perf_wr_q <= perf_wr_d;
    end
  end

  assign perf_reads  = perf_rd_q;
  assign perf_writes = perf_wr_q;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: transaction-level model plus directed literal checks.
module tb_cacheline_adapter;
  import cacheline_adapter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_read = 1'b0;
  logic        line_write = 1'b0;
  logic [31:0] line_address = '0;
  line_t       line_wdata = '0;
  line_t       line_rdata;
  logic        line_resp;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  beat_t       burst_o;
  beat_t       burst_i = '0;
  logic        resp_i = 1'b0;
`ifdef ADAPTER_PERF_CNT_EN
  logic [31:0] perf_reads;
  logic [31:0] perf_writes;
`endif

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
`ifdef ADAPTER_PERF_CNT_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: kind 0 = idle, 1 = line fill, 2 = writeback.
  int          m_kind = 0;
  int          m_done = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  line_t       m_wline = '0;
  line_t       m_rline = '0;
  int          m_prd = 0;
  int          m_pwr = 0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_kind = 0; m_done = 0; m_pend = 1'b0; m_addr = '0;
      m_wline = '0; m_rline = '0; m_prd = 0; m_pwr = 0;
      chk_en = 1'b1;
    end else if (m_pend) begin
      m_pend = 1'b0;
    end else if (m_kind == 0) begin
      if (line_write || line_read) begin
        m_addr = {line_address[31:5], 5'b0};
        m_done = 0;
        m_kind = line_write ? 2 : 1;
        if (line_write) m_wline = line_wdata;
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_rline[m_done*64 +: 64] = burst_i;
      m_done++;
      if (m_done == 4) begin
        if (m_kind == 1) m_prd++;
        else m_pwr++;
        m_kind = 0;
        m_pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("read_o", read_o, m_kind == 1);
      chk("write_o", write_o, m_kind == 2);
      chk("line_resp", line_resp, m_pend);
      chk("address_o", address_o, m_addr);
      chk("line_rdata", line_rdata, m_rline);
      if (m_kind == 2) chk("burst_o", burst_o, m_wline[m_done*64 +: 64]);
`ifdef ADAPTER_PERF_CNT_EN
      chk("perf_reads", perf_reads, m_prd);
      chk("perf_writes", perf_writes, m_pwr);
`endif
    end
  end

  beat_t beats[4];
  int    gaps[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input beat_t b0, input beat_t b1, input beat_t b2, input beat_t b3,
                           input int g0, input int g1, input int g2, input int g3);
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
  endtask

  // Issues one request, answers the burst with beats[]/gaps[], checks the completion pulse.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input line_t wd);
    int  waited;
    bit  seen;
    line_read = rd; line_write = wr; line_address = addr; line_wdata = wd;
    waited = 0;
    seen = 1'b0;
    while (!seen && waited < 8) begin
      tick();
      waited++;
      seen = read_o | write_o;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL start_timeout: got no read_o/write_o expected a burst");
      line_read = 1'b0; line_write = 1'b0;
      return;
    end
    chk("start_latency", waited, 1);
    chk("first_op_is_write", write_o, wr);
    chk("burst_addr", address_o, {addr[31:5], 5'b0});
    if (wr) chk("first_beat", burst_o, wd[63:0]);
    for (int b = 0; b < 4; b++) begin
      repeat (gaps[b]) tick();
      resp_i = 1'b1; burst_i = beats[b];
      tick();
      resp_i = 1'b0; burst_i = '0;
    end
    chk("resp_latency", line_resp, 1'b1);
    line_read = 1'b0; line_write = 1'b0;
    tick();
    chk("resp_one_cycle", line_resp, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_line_resp", line_resp, 1'b0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_burst_o", burst_o, 64'h0);
    chk("rst_line_rdata", line_rdata, 256'h0);
    rst = 1'b0;
    tick();

    // 1: plain read, back-to-back beats
    set_beats(64'h1111111111111111, 64'h2222222222222222,
              64'h3333333333333333, 64'h4444444444444444, 0, 0, 0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_1234, '0);
    chk("t1_rdata", line_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("t1_address", address_o, 32'h0000_1220);

    // 2: writeback, low beat first
    set_beats('0, '0, '0, '0, 0, 0, 0, 0);
    run_txn(1'b0, 1'b1, 32'hDEAD_BEEF,
            256'h0123456789ABCDEF_1122334455667788_99AABBCCDDEEFF00_0F1E2D3C4B5ACDEF);
    chk("t2_address", address_o, 32'hDEAD_BEE0);
    chk("t2_rdata_held", line_rdata,
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // 3: stalled memory
    set_beats(64'hA0A0A0A0A0A0A0A0, 64'hB1B1B1B1B1B1B1B1,
              64'hC2C2C2C2C2C2C2C2, 64'hD3D3D3D3D3D3D3D3, 2, 0, 3, 1);
    run_txn(1'b1, 1'b0, 32'h8000_0040, '0);
    chk("t3_rdata", line_rdata,
        256'hD3D3D3D3D3D3D3D3_C2C2C2C2C2C2C2C2_B1B1B1B1B1B1B1B1_A0A0A0A0A0A0A0A0);

    // 4: both requests -> write wins, then the read
    set_beats('0, '0, '0, '0, 1, 0, 0, 2);
    run_txn(1'b1, 1'b1, 32'h0000_0100, {4{64'hFACE_0000_0000_CAFE}});
    set_beats(64'h0101010101010101, 64'h0202020202020202,
              64'h0303030303030303, 64'h0404040404040404, 0, 1, 0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0100, '0);

    // stray resp_i while idle must be ignored
    resp_i = 1'b1; burst_i = 64'hBADBADBADBADBAD0;
    repeat (2) tick();
    resp_i = 1'b0; burst_i = '0;
    tick();
    chk("stray_rdata", line_rdata,
        256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101);
    chk("stray_read_o", read_o, 1'b0);

    // 5: reset after two read beats
    line_read = 1'b1; line_address = 32'h0000_2000;
    tick();
    chk("t5_read_o", read_o, 1'b1);
    for (int b = 0; b < 2; b++) begin
      resp_i = 1'b1; burst_i = 64'h5555555555555555;
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    rst = 1'b1; line_read = 1'b0;
    tick();
    chk("t5_rst_read_o", read_o, 1'b0);
    chk("t5_rst_resp", line_resp, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_resp", line_resp, 1'b0);
    end
    set_beats(64'h6666666666666666, 64'h7777777777777777,
              64'h8888888888888888, 64'h9999999999999999, 0, 0, 1, 0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, '0);
    chk("t5_rdata", line_rdata,
        256'h9999999999999999_8888888888888888_7777777777777777_6666666666666666);

    // 6: two more reads and two writes after the reset
    set_beats(64'h1, 64'h2, 64'h3, 64'h4, 0, 0, 0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_3000, '0);
    run_txn(1'b0, 1'b1, 32'h0000_3020, {64'hD, 64'hC, 64'hB, 64'hA});
    run_txn(1'b1, 1'b0, 32'h0000_3040, '0);
    run_txn(1'b0, 1'b1, 32'h0000_3060, {64'h4D, 64'h3C, 64'h2B, 64'h1A});
    chk("t6_rdata", line_rdata, {64'h4, 64'h3, 64'h2, 64'h1});
`ifdef ADAPTER_PERF_CNT_EN
    resp_i = 1'b1;
    tick();
    resp_i = 1'b0;
    tick();
    chk("t6_perf_reads", perf_reads, 32'd3);
    chk("t6_perf_writes", perf_writes, 32'd2);
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
